// File: rtl/pack24_bot_scheduler_pkg.sv
// Shared constants for the pack24 scheduling slice: bot memory geometry, pack result
// widths and the scheduler state encoding.
package pack24_bot_scheduler_pkg;

    localparam int unsigned BOT_ADDR_WIDTH = 14;
    localparam int unsigned FULL_WIDTH     = 5;
    localparam int unsigned SUM_DATA_WIDTH = 40;
    localparam int unsigned PCOEFF_WIDTH   = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } schedState_e;

endpackage

// File: rtl/pack24_result_accumulator.sv
// Result side of the scheduler: gates pack results, tracks outstanding bots, accumulates
// job totals and flags results that arrive when none are expected.
module pack24_result_accumulator
    import pack24_bot_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BOT_ADDR_WIDTH,
    parameter int unsigned SUM_WIDTH  = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      active,
    input  logic                      issue,
    input  logic                      resultValid,
    input  logic [SUM_DATA_WIDTH-1:0] summedData,
    input  logic [PCOEFF_WIDTH-1:0]   pcoeffCount,
    output logic                      resultTaken,
    output logic [ADDR_WIDTH:0]       outstanding,
    output logic [SUM_WIDTH-1:0]      totalSum,
    output logic [CNT_WIDTH-1:0]      totalCount,
    output logic                      protocolError
);

    logic [ADDR_WIDTH:0]  outstandingQ, outstandingD;
    logic [SUM_WIDTH-1:0] totalSumQ, totalSumD;
    logic [CNT_WIDTH-1:0] totalCountQ, totalCountD;
    logic                 protocolErrorQ;
    logic                 badResult;

    // A result only counts while a job is running and something is actually in flight.
    assign resultTaken = resultValid && active && (outstandingQ != '0);
    assign badResult   = resultValid && !resultTaken;

    always_comb begin
        outstandingD = outstandingQ;
        totalSumD    = totalSumQ;
        totalCountD  = totalCountQ;
        if (clear) begin
            outstandingD = '0;
            totalSumD    = '0;
            totalCountD  = '0;
        end else begin
            unique case ({issue, resultTaken})
                2'b10:   outstandingD = outstandingQ + 1'b1;
                2'b01:   outstandingD = outstandingQ - 1'b1;
                default: outstandingD = outstandingQ;
            endcase
            if (resultTaken) begin
                totalSumD   = totalSumQ + SUM_WIDTH'(summedData);
                totalCountD = totalCountQ + CNT_WIDTH'(pcoeffCount);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstandingQ   <= '0;
            totalSumQ      <= '0;
            totalCountQ    <= '0;
            protocolErrorQ <= 1'b0;
        end else begin
            outstandingQ   <= outstandingD;
            totalSumQ      <= totalSumD;
            totalCountQ    <= totalCountD;
            protocolErrorQ <= protocolErrorQ | badResult;
        end
    end

    assign outstanding   = outstandingQ;
    assign totalSum      = totalSumQ;
    assign totalCount    = totalCountQ;
    assign protocolError = protocolErrorQ;

endmodule

// File: rtl/pack24_bot_scheduler.sv
// Job sequencer in front of pipeline24Pack: streams a contiguous bot index range under
// fullness back-pressure and reports per-job totals with a done pulse.
module pack24_bot_scheduler
    import pack24_bot_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = BOT_ADDR_WIDTH,
    parameter int unsigned FULL_THRESHOLD = 30,
    parameter int unsigned SUM_WIDTH      = 64,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [127:0]              jobTop,
    input  logic [ADDR_WIDTH-1:0]     jobBase,
    input  logic [ADDR_WIDTH:0]       jobCount,
    output logic                      ready,
    output logic [127:0]              top,
    output logic [ADDR_WIDTH-1:0]     botIndex,
    output logic                      isBotValid,
    input  logic [FULL_WIDTH-1:0]     maxFullness,
    input  logic                      resultValid,
    input  logic [SUM_DATA_WIDTH-1:0] summedData,
    input  logic [PCOEFF_WIDTH-1:0]   pcoeffCount,
    output logic                      done,
    output logic [SUM_WIDTH-1:0]      totalSum,
    output logic [CNT_WIDTH-1:0]      totalCount,
    output logic                      protocolError
);

    schedState_e           stateQ, stateD;
    logic [127:0]          topQ;
    logic [ADDR_WIDTH-1:0] baseQ;
    logic [ADDR_WIDTH:0]   countQ;
    logic [ADDR_WIDTH:0]   issuedQ;
    logic [ADDR_WIDTH:0]   issuedPlus;
    logic [ADDR_WIDTH:0]   outstanding;
    logic                  accept;
    logic                  issue;
    logic                  allIssued;
    logic                  drainEmpty;
    logic                  resultTaken;
    logic                  active;

    assign accept     = (stateQ == StIdle) && start;
    assign active     = (stateQ == StIssue) || (stateQ == StDrain);
    assign issuedPlus = issuedQ + 1'b1;
    // Issue decision is combinational on the current fullness: the threshold already
    // leaves room for the pack's input latency, so no skid buffer is needed.
    assign issue      = (stateQ == StIssue) && (issuedQ < countQ)
                        && (32'(maxFullness) < FULL_THRESHOLD);
    assign allIssued  = (issuedQ == countQ) || (issue && (issuedPlus == countQ));
    assign drainEmpty = (outstanding == '0)
                        || ((outstanding == (ADDR_WIDTH + 1)'(1)) && resultTaken);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  if (start) stateD = StIssue;
            StIssue: if (allIssued) stateD = StDrain;
            StDrain: if (drainEmpty) stateD = StDone;
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        ready      = (stateQ == StIdle);
        done       = (stateQ == StDone);
        isBotValid = issue;
        botIndex   = '0;
        if (issue) begin
            botIndex = baseQ + issuedQ[ADDR_WIDTH-1:0];
        end
    end

    // Job registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            topQ    <= '0;
            baseQ   <= '0;
            countQ  <= '0;
            issuedQ <= '0;
        end else if (accept) begin
            topQ    <= jobTop;
            baseQ   <= jobBase;
            countQ  <= jobCount;
            issuedQ <= '0;
        end else if (issue) begin
            issuedQ <= issuedPlus;
        end
    end

    assign top = topQ;

    pack24_result_accumulator #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .SUM_WIDTH (SUM_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) uAcc (
        .clk          (clk),
        .rst          (rst),
        .clear        (accept),
        .active       (active),
        .issue        (issue),
        .resultValid  (resultValid),
        .summedData   (summedData),
        .pcoeffCount  (pcoeffCount),
        .resultTaken  (resultTaken),
        .outstanding  (outstanding),
        .totalSum     (totalSum),
        .totalCount   (totalCount),
        .protocolError(protocolError)
    );

endmodule

// File: tb/tb_pack24_bot_scheduler.sv
// Randomised bench for pack24_bot_scheduler with a cycle-level job/pack reference model.
module tb_pack24_bot_scheduler;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [127:0]  jobTop;
    logic [AW-1:0] jobBase;
    logic [AW:0]   jobCount;
    logic          ready;
    logic [127:0]  top;
    logic [AW-1:0] botIndex;
    logic          isBotValid;
    logic [4:0]    maxFullness;
    logic          resultValid;
    logic [39:0]   summedData;
    logic [4:0]    pcoeffCount;
    logic          done;
    logic [63:0]   totalSum;
    logic [31:0]   totalCount;
    logic          protocolError;

    int checks   = 0;
    int failures = 0;

    bit              errExp  = 1'b0;
    longint unsigned lastSum = 0;
    int unsigned     lastCnt = 0;

    always #5 clk = ~clk;

    pack24_bot_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .jobTop       (jobTop),
        .jobBase      (jobBase),
        .jobCount     (jobCount),
        .ready        (ready),
        .top          (top),
        .botIndex     (botIndex),
        .isBotValid   (isBotValid),
        .maxFullness  (maxFullness),
        .resultValid  (resultValid),
        .summedData   (summedData),
        .pcoeffCount  (pcoeffCount),
        .done         (done),
        .totalSum     (totalSum),
        .totalCount   (totalCount),
        .protocolError(protocolError)
    );

    // Tasks start and end 1 time unit after a rising edge; outputs are sampled 4 units later.
    task automatic accept_job(input logic [127:0] tg, input int base, input int cnt);
        start       = 1'b1;
        jobTop      = tg;
        jobBase     = AW'(base);
        jobCount    = (AW + 1)'(cnt);
        resultValid = 1'b0;
        maxFullness = '0;
        #4;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: got %b expected 1", ready);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // bpMode: 0 none, 1 random, 2 fixed stall window. dataMode: 0 random, 1 ramp, 2 all-ones.
    task automatic run_job(input string name, input int base, input int cnt, input int bpMode,
                           input int maxLat, input int dataMode);
        logic [127:0]    tg;
        int              nIss, nRes, lastRes, lastDue, budget, due;
        int              dueQ[$];
        longint unsigned eSum;
        int unsigned     eCnt;
        bit              fin, expIssue, expDone;
        logic [4:0]      f;
        logic [39:0]     d;
        logic [4:0]      pc;

        tg = {$urandom(), $urandom(), $urandom(), $urandom()};
        accept_job(tg, base, cnt);
        nIss = 0; nRes = 0; lastRes = -10; lastDue = -1;
        eSum = 0; eCnt = 0; fin = 1'b0;
        budget = cnt * 40 + 50;
        for (int t = 0; t < budget && !fin; t++) begin
            case (bpMode)
                1:       f = ($urandom_range(0, 99) < 30) ? 5'($urandom_range(30, 31))
                                                          : 5'($urandom_range(0, 29));
                2:       f = (t >= 2 && t <= 6) ? 5'd30 : ((t == 7) ? 5'd29 : 5'd0);
                default: f = 5'd0;
            endcase
            maxFullness = f;
            if (dueQ.size() > 0 && dueQ[0] <= t) begin
                void'(dueQ.pop_front());
                case (dataMode)
                    1:       begin d = 40'(10 * (nRes + 1)); pc = 5'(nRes + 1); end
                    2:       begin d = '1; pc = 5'd31; end
                    default: begin d = 40'({$urandom(), $urandom()}); pc = 5'($urandom()); end
                endcase
                resultValid = 1'b1;
                summedData  = d;
                pcoeffCount = pc;
                eSum += 64'(d);
                eCnt += 32'(pc);
                nRes++;
                if (nRes == cnt) lastRes = t;
            end else begin
                resultValid = 1'b0;
            end
            #4;
            expIssue = (nIss < cnt) && (f < 5'd30);
            checks++;
            if (isBotValid !== expIssue) begin
                failures++;
                $display("FAIL %s_valid t=%0d: got %b expected %b", name, t, isBotValid, expIssue);
            end
            if (expIssue) begin
                checks++;
                if (botIndex !== AW'((base + nIss) % 16384)) begin
                    failures++;
                    $display("FAIL %s_index t=%0d: got %0d expected %0d", name, t, botIndex,
                             (base + nIss) % 16384);
                end
                due = t + $urandom_range(1, maxLat);
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                dueQ.push_back(due);
                nIss++;
            end
            expDone = (cnt == 0) ? (t == 2) : (nRes == cnt && lastRes == t - 1);
            checks++;
            if (done !== expDone) begin
                failures++;
                $display("FAIL %s_done t=%0d: got %b expected %b", name, t, done, expDone);
            end
            if (expDone) begin
                fin = 1'b1;
                checks++;
                if (totalSum !== eSum || totalCount !== eCnt) begin
                    failures++;
                    $display("FAIL %s_totals: got %0d/%0d expected %0d/%0d", name, totalSum,
                             totalCount, eSum, eCnt);
                end
                checks++;
                if (top !== tg) begin
                    failures++;
                    $display("FAIL %s_top: got %h expected %h", name, top, tg);
                end
                checks++;
                if (protocolError !== errExp) begin
                    failures++;
                    $display("FAIL %s_err: got %b expected %b", name, protocolError, errExp);
                end
            end else begin
                checks++;
                if (ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_busy t=%0d: got ready=%b expected 0", name, t, ready);
                end
            end
            @(posedge clk);
            #1;
        end
        resultValid = 1'b0;
        maxFullness = '0;
        if (!fin) begin
            failures++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
        lastSum = eSum;
        lastCnt = eCnt;
        #4;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || totalSum !== eSum || totalCount !== eCnt) begin
            failures++;
            $display("FAIL %s_after: got ready=%b done=%b sum=%0d cnt=%0d expected 1 0 %0d %0d",
                     name, ready, done, totalSum, totalCount, eSum, eCnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (ready !== 1'b1 || isBotValid !== 1'b0 || botIndex !== '0 || top !== '0
            || done !== 1'b0 || totalSum !== '0 || totalCount !== '0 || protocolError !== 1'b0)
        begin
            failures++;
            $display("FAIL %s: got rdy=%b v=%b idx=%0d top=%h done=%b sum=%0d cnt=%0d err=%b expected reset values",
                     name, ready, isBotValid, botIndex, top, done, totalSum, totalCount,
                     protocolError);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        #4;
        check_reset_state("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        errExp = 1'b0;
    endtask

    task automatic test_basic();
        run_job("basic", 100, 4, 0, 1, 1);
    endtask

    task automatic test_backpressure();
        run_job("backpressure", 2000, 10, 2, 3, 0);
    endtask

    task automatic test_wrap_and_empty();
        run_job("wrap", 16382, 4, 0, 3, 0);
        run_job("empty", 77, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        run_job("simultaneous", 300, 20, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            run_job("random", int'($urandom_range(0, 16383)), int'($urandom_range(1, 40)), 1, 5, 0);
        end
    endtask

    task automatic test_spurious();
        resultValid = 1'b1;
        summedData  = 40'h12_3456_789a;
        pcoeffCount = 5'd7;
        @(posedge clk);
        #1;
        resultValid = 1'b0;
        errExp = 1'b1;
        #4;
        checks++;
        if (protocolError !== 1'b1 || totalSum !== lastSum || totalCount !== lastCnt) begin
            failures++;
            $display("FAIL spurious_idle: got err=%b sum=%0d cnt=%0d expected 1 %0d %0d",
                     protocolError, totalSum, totalCount, lastSum, lastCnt);
        end
        repeat (2) @(posedge clk);
        #1;
        #4;
        checks++;
        if (protocolError !== 1'b1) begin
            failures++;
            $display("FAIL spurious_sticky: got %b expected 1", protocolError);
        end
        @(posedge clk);
        #1;
        run_job("after_spurious", 50, 3, 0, 2, 0);
    endtask

    task automatic test_reset_mid();
        accept_job(128'hdead_beef, 500, 8);
        for (int t = 0; t < 2; t++) begin
            #4;
            checks++;
            if (isBotValid !== 1'b1 || botIndex !== AW'(500 + t)) begin
                failures++;
                $display("FAIL midreset_issue t=%0d: got v=%b idx=%0d expected 1 %0d", t,
                         isBotValid, botIndex, 500 + t);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check_reset_state("midreset_state");
        errExp = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_job("after_reset", 0, 1, 0, 3, 0);
    endtask

    task automatic test_accumulator_width();
        run_job("width", 0, 16384, 0, 2, 2);
        checks++;
        if (lastSum !== 64'd16384 * 64'hff_ffff_ffff) begin
            failures++;
            $display("FAIL width_model: got %0d expected %0d", lastSum,
                     64'd16384 * 64'hff_ffff_ffff);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        jobTop      = '0;
        jobBase     = '0;
        jobCount    = '0;
        maxFullness = '0;
        resultValid = 1'b0;
        summedData  = '0;
        pcoeffCount = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_and_empty();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_accumulator_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
